vga_frame_reader: RTL and testbench

//  Read side of the ping-pong 1-bit frame buffer. Generates 640x480@60 VGA timing and

---
 rtl/vga_frame_reader.sv | 148 ++++++++++++++
 tb/tb_vga_frame_reader.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/vga_frame_reader.sv
// Read side of the ping-pong 1-bit frame buffer: VGA timing, window reads, RGB565 out.
// Latency 3 clks from counter position to vga_rgb/hs/vs/de; no backpressure (free-running pixel clock).
module vga_frame_reader #(
  parameter int H_ACT  = 640,
  parameter int H_FP   = 16,
  parameter int H_SYN  = 96,
  parameter int H_BP   = 48,
  parameter int V_ACT  = 480,
  parameter int V_FP   = 10,
  parameter int V_SYN  = 2,
  parameter int V_BP   = 33,
  parameter int WIN_X0 = 160,
  parameter int WIN_W  = 320,
  parameter int WIN_Y0 = 140,
  parameter int WIN_H  = 200,
  parameter logic [15:0] FG     = 16'hFFFF,
  parameter logic [15:0] BG     = 16'h0000,
  parameter logic [15:0] BORDER = 16'h001F
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_end,
  input  logic        ram_q,
  output logic [15:0] rd_addr,
  output logic        rd_en,
  output logic        rd_end,
  output logic        rd_addr_sel,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        vga_de,
  output logic [15:0] vga_rgb
);

  localparam logic [9:0] H_LAST = 10'(H_ACT + H_FP + H_SYN + H_BP - 1);
  localparam logic [9:0] H_PRE  = 10'(H_ACT + H_FP + H_SYN + H_BP - 2);
  localparam logic [9:0] V_LAST = 10'(V_ACT + V_FP + V_SYN + V_BP - 1);
  localparam logic [9:0] HA     = 10'(H_ACT);
  localparam logic [9:0] VA     = 10'(V_ACT);
  localparam logic [9:0] HS0    = 10'(H_ACT + H_FP);
  localparam logic [9:0] HS1    = 10'(H_ACT + H_FP + H_SYN);
  localparam logic [9:0] VS0    = 10'(V_ACT + V_FP);
  localparam logic [9:0] VS1    = 10'(V_ACT + V_FP + V_SYN);
  localparam logic [9:0] WX0    = 10'(WIN_X0);
  localparam logic [9:0] WX1    = 10'(WIN_X0 + WIN_W);
  localparam logic [9:0] WY0    = 10'(WIN_Y0);
  localparam logic [9:0] WY1    = 10'(WIN_Y0 + WIN_H);

  typedef enum logic {WAIT_FIRST, SHOW} state_t;

  state_t      state;
  logic [9:0]  h_cnt, v_cnt;
  logic [15:0] addr_cnt;
  logic        h_wrap, active, in_win, hs_now, vs_now, fetch;
  logic        de1, hs1, vs1, win1, show1;
  logic        de2, hs2, vs2, win2, show2;

  assign h_wrap = (h_cnt == H_LAST);
  assign active = (h_cnt < HA) && (v_cnt < VA);
  assign in_win = (h_cnt >= WX0) && (h_cnt < WX1) && (v_cnt >= WY0) && (v_cnt < WY1);
  assign hs_now = !((h_cnt >= HS0) && (h_cnt < HS1));
  assign vs_now = !((v_cnt >= VS0) && (v_cnt < VS1));
  assign fetch  = in_win && (state == SHOW);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else begin
      h_cnt <= h_wrap ? 10'd0 : h_cnt + 10'd1;
      if (h_wrap)
        v_cnt <= (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
    end
  end

  // rd_end is decoded one clk early so it is registered yet coincides with the last position.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= WAIT_FIRST;
      rd_end      <= 1'b0;
      rd_addr_sel <= 1'b1;
    end else begin
      rd_end <= (h_cnt == H_PRE) && (v_cnt == V_LAST);
      if (rd_end && wr_end) begin
        rd_addr_sel <= ~rd_addr_sel;
        state       <= SHOW;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_en    <= 1'b0;
      rd_addr  <= '0;
      addr_cnt <= '0;
      de1      <= 1'b0;
      hs1      <= 1'b1;
      vs1      <= 1'b1;
      win1     <= 1'b0;
      show1    <= 1'b0;
    end else begin
      rd_en <= fetch;
      if (rd_end) begin
        addr_cnt <= '0;
      end else if (fetch) begin
        rd_addr  <= addr_cnt;
        addr_cnt <= addr_cnt + 16'd1;
      end
      de1   <= active;
      hs1   <= hs_now;
      vs1   <= vs_now;
      win1  <= in_win;
      show1 <= (state == SHOW);
    end
  end

  // Stage 2 waits for ram_q; stage 3 produces the pixel with its aligned sync/de.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      de2     <= 1'b0;
      hs2     <= 1'b1;
      vs2     <= 1'b1;
      win2    <= 1'b0;
      show2   <= 1'b0;
      vga_de  <= 1'b0;
      vga_hs  <= 1'b1;
      vga_vs  <= 1'b1;
      vga_rgb <= '0;
    end else begin
      de2    <= de1;
      hs2    <= hs1;
      vs2    <= vs1;
      win2   <= win1;
      show2  <= show1;
      vga_de <= de2;
      vga_hs <= hs2;
      vga_vs <= vs2;
      if (!de2)
        vga_rgb <= 16'h0000;
      else if (!win2)
        vga_rgb <= BORDER;
      else if (show2 && ram_q)
        vga_rgb <= FG;
      else
        vga_rgb <= BG;
    end
  end

endmodule

// File: tb/tb_vga_frame_reader.sv
// Bench for vga_frame_reader on a scaled-down timing grid so several whole frames fit in a short run.
module tb_vga_frame_reader;

  localparam int HA = 40, HFP = 2, HSY = 4, HBP = 3;
  localparam int VA = 20, VFP = 2, VSY = 2, VBP = 3;
  localparam int WX0 = 8, WW = 16, WY0 = 5, WH = 8;
  localparam int HT = HA + HFP + HSY + HBP;
  localparam int VT = VA + VFP + VSY + VBP;
  localparam int F  = HT * VT;
  localparam int NWIN = WW * WH;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_end;
  logic        ram_q = 1'b0;
  logic [15:0] rd_addr;
  logic        rd_en, rd_end, rd_addr_sel;
  logic        vga_hs, vga_vs, vga_de;
  logic [15:0] vga_rgb;

  vga_frame_reader #(
    .H_ACT(HA), .H_FP(HFP), .H_SYN(HSY), .H_BP(HBP),
    .V_ACT(VA), .V_FP(VFP), .V_SYN(VSY), .V_BP(VBP),
    .WIN_X0(WX0), .WIN_W(WW), .WIN_Y0(WY0), .WIN_H(WH),
    .FG(16'hFFFF), .BG(16'h0000), .BORDER(16'h001F)
  ) dut (
    .clk(clk), .rst_n(rst_n), .wr_end(wr_end), .ram_q(ram_q),
    .rd_addr(rd_addr), .rd_en(rd_en), .rd_end(rd_end), .rd_addr_sel(rd_addr_sel),
    .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_de(vga_de), .vga_rgb(vga_rgb)
  );

  always #5 clk = ~clk;

  // Buffer 0 holds addr[0] stripes, buffer 1 a true checkerboard.
  function automatic logic pat(input logic s, input logic [15:0] a);
    return s ? (a[0] ^ a[4]) : a[0];
  endfunction

  always @(posedge clk) if (rd_en) ram_q <= pat(rd_addr_sel, rd_addr);

  typedef struct { logic en; logic [15:0] addr; } exp_rd_t;
  typedef struct {
    int   frames;
    int   wr_mode;   // 0 low, 1 mid pulse only, 2 at frame end only, 3 whole frame
    logic exp_sel;
    int   exp_rden;
    int   exp_de;
    int   exp_rdend;
  } phase_t;

  exp_rd_t     q_rd[$];
  logic [18:0] q_vid[$];
  int   n_checks = 0, n_fail = 0;
  int   k;
  logic sel_m, show_m;
  int   rden_cnt, de_cnt, rdend_cnt, first_addr, last_addr;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at k=%0d: got %h expected %h", name, k, act, exp);
    end
  endtask

  task automatic model_reset();
    k = 0;
    sel_m = 1'b1;
    show_m = 1'b0;
    q_rd.delete();
    q_vid.delete();
  endtask

  task automatic clear_counts();
    rden_cnt = 0; de_cnt = 0; rdend_cnt = 0; first_addr = -1; last_addr = -1;
  endtask

  // Called at a negedge with wr_end already set for the current position k.
  task automatic step();
    exp_rd_t     er;
    logic [18:0] ev;
    int f, h, v;
    logic de, win, hs, vs;
    logic [15:0] ea, rgb;
    if (k >= 1) begin
      er = q_rd.pop_front();
      check("rd_en", 64'(rd_en), 64'(er.en));
      if (er.en) check("rd_addr", 64'(rd_addr), 64'(er.addr));
    end
    if (k >= 3) begin
      ev = q_vid.pop_front();
      check("video", 64'({vga_de, vga_hs, vga_vs, vga_rgb}), 64'(ev));
    end
    f = k % F; h = f % HT; v = f / HT;
    de  = (h < HA) && (v < VA);
    win = (h >= WX0) && (h < WX0 + WW) && (v >= WY0) && (v < WY0 + WH);
    hs  = !((h >= HA + HFP) && (h < HA + HFP + HSY));
    vs  = !((v >= VA + VFP) && (v < VA + VFP + VSY));
    ea  = 16'((h - WX0) + WW * (v - WY0));
    if (!de) rgb = 16'h0000;
    else if (!win) rgb = 16'h001F;
    else if (show_m && pat(sel_m, ea)) rgb = 16'hFFFF;
    else rgb = 16'h0000;
    er.en = win && show_m;
    er.addr = ea;
    q_rd.push_back(er);
    q_vid.push_back({de, hs, vs, rgb});
    check("rd_end_sel", 64'({rd_end, rd_addr_sel}), 64'({f == F - 1, sel_m}));
    if (rd_en) begin
      rden_cnt++;
      if (first_addr < 0) first_addr = int'(rd_addr);
      last_addr = int'(rd_addr);
    end
    if (vga_de) de_cnt++;
    if (rd_end) rdend_cnt++;
    if (f == F - 1 && wr_end) begin
      sel_m = ~sel_m;
      show_m = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    k++;
  endtask

  task automatic run_frame(input int mode);
    for (int p = 0; p < F; p++) begin
      if (p == F - 1) wr_end = (mode >= 2);
      else wr_end = (mode == 3) || (mode == 1 && p >= F / 2 && p < F / 2 + 5);
      step();
    end
  endtask

  localparam logic [37:0] RST_VAL = {1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000};

  phase_t ph[7];

  initial begin
    ph[0] = '{2, 0, 1'b1, 0,    2 * HA * VA, 2};
    ph[1] = '{1, 0, 1'b1, 0,    HA * VA,     1};
    ph[2] = '{1, 2, 1'b0, 0,    HA * VA,     1};
    ph[3] = '{1, 0, 1'b0, NWIN, HA * VA,     1};
    ph[4] = '{1, 1, 1'b0, NWIN, HA * VA,     1};
    ph[5] = '{1, 3, 1'b1, NWIN, HA * VA,     1};
    ph[6] = '{1, 2, 1'b0, NWIN, HA * VA,     1};

    rst_n = 1'b0;
    wr_end = 1'b0;
    k = 0;
    repeat (3) @(negedge clk);
    check("reset_outs", 64'({rd_en, rd_addr, rd_end, rd_addr_sel, vga_hs, vga_vs, vga_de, vga_rgb}),
          64'(RST_VAL));
    rst_n = 1'b1;
    model_reset();

    for (int i = 0; i < 7; i++) begin
      clear_counts();
      for (int fr = 0; fr < ph[i].frames; fr++) run_frame(ph[i].wr_mode);
      check($sformatf("ph%0d_sel", i), 64'(rd_addr_sel), 64'(ph[i].exp_sel));
      check($sformatf("ph%0d_rden", i), 64'(rden_cnt), 64'(ph[i].exp_rden));
      check($sformatf("ph%0d_de", i), 64'(de_cnt), 64'(ph[i].exp_de));
      check($sformatf("ph%0d_rdend", i), 64'(rdend_cnt), 64'(ph[i].exp_rdend));
      if (ph[i].exp_rden > 0) begin
        check($sformatf("ph%0d_first_addr", i), 64'(first_addr), 64'(0));
        check($sformatf("ph%0d_last_addr", i), 64'(last_addr), 64'(NWIN - 1));
      end
    end

    // Reset asynchronously while reading inside the window.
    wr_end = 1'b0;
    for (int p = 0; p < 8 * HT + 12; p++) step();
    check("pre_reset_rd_en", 64'(rd_en), 64'(1));
    #2 rst_n = 1'b0;
    #1 check("async_reset_outs",
             64'({rd_en, rd_addr, rd_end, rd_addr_sel, vga_hs, vga_vs, vga_de, vga_rgb}), 64'(RST_VAL));
    @(negedge clk);
    check("held_reset_outs",
          64'({rd_en, rd_addr, rd_end, rd_addr_sel, vga_hs, vga_vs, vga_de, vga_rgb}), 64'(RST_VAL));
    rst_n = 1'b1;
    model_reset();
    clear_counts();
    run_frame(0);
    check("post_reset_rden", 64'(rden_cnt), 64'(0));
    check("post_reset_rdend", 64'(rdend_cnt), 64'(1));
    check("post_reset_sel", 64'(rd_addr_sel), 64'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
